// File: rtl/mem_line_responder.sv
// Fixed-latency, line-granular memory responder for the cache memory port (128-bit lines).
// Optional protocol checking is compiled in with `define MEM_RESP_PROTO_CHK_EN; otherwise proto_err is tied to 0.
module mem_line_responder #(
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 4
) (
   input  logic         clk,
   input  logic         proc_reset,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [27:0]  mem_addr,
   input  logic [127:0] mem_wdata,
   output logic [127:0] mem_rdata,
   output logic         mem_ready,
   output logic         proto_err
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

   logic [127:0] line_mem [2**DEPTH_LOG2];

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic                  is_wr_q, is_wr_d;
   logic [127:0]          wdata_q, wdata_d;
   logic                  ready_q, ready_d;
   logic [127:0]          rdata_q;
   logic                  done;

   // Upper address bits alias onto the array; they are deliberately dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^mem_addr[27:DEPTH_LOG2];

   assign done = (state_q == S_BUSY) && (cnt_q == 4'd0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      is_wr_d = is_wr_q;
      wdata_d = wdata_q;
      ready_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mem_read || mem_write) begin
               idx_d   = mem_addr[DEPTH_LOG2-1:0];
               is_wr_d = mem_write;
               if (mem_write) begin
                  wdata_d = mem_wdata;
               end
               cnt_d   = 4'(LATENCY - 1);
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (cnt_q == 4'd0) begin
               ready_d = 1'b1;
               state_d = S_RELEASE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RELEASE: begin
            // Wait for the requester to drop its level so the same request is not served twice.
            if (!mem_read && !mem_write) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (proc_reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         is_wr_q <= 1'b0;
         wdata_q <= '0;
         ready_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         is_wr_q <= is_wr_d;
         wdata_q <= wdata_d;
         ready_q <= ready_d;
         if (done && !is_wr_q) begin
            rdata_q <= line_mem[idx_q];
         end
      end
   end

   // Array is never cleared; a reset on the commit edge suppresses the write.
   always_ff @(posedge clk) begin
      if (done && is_wr_q && !proc_reset) begin
         line_mem[idx_q] <= wdata_q;
      end
   end

   assign mem_rdata = rdata_q;
   assign mem_ready = ready_q;

`ifdef MEM_RESP_PROTO_CHK_EN
   logic proto_err_q, proto_err_d;

   always_comb begin
      proto_err_d = proto_err_q;
      if (state_q == S_BUSY) begin
         if (is_wr_q ? !mem_write : !mem_read) begin
            proto_err_d = 1'b1;
         end
      end
      if (state_q == S_IDLE && mem_read && mem_write) begin
         proto_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (proc_reset) begin
         proto_err_q <= 1'b0;
      end else begin
         proto_err_q <= proto_err_d;
      end
   end

   assign proto_err = proto_err_q;
`else
   assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed and randomized checks of mem_line_responder against a line-array reference model.
module tb_mem_line_responder;
   localparam int LAT = 4;

   logic         clk;
   logic         proc_reset;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;
   logic         proto_err;

   int checks = 0;
   int errors = 0;

   logic [127:0] ref_mem [256];
   logic [127:0] exp_rdata;
   logic         exp_proto;

   mem_line_responder #(.DEPTH_LOG2(8), .LATENCY(LAT)) dut (
      .clk(clk),
      .proc_reset(proc_reset),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ready(mem_ready),
      .proto_err(proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One complete transaction: request sampled at E0, held for hold extra cycles after the
   // ready cycle, or dropped after edge drop_at (drop_at < 0 means never dropped early).
   task automatic txn(input logic rd, input logic wr, input logic [27:0] addr,
                      input logic [127:0] wd, input int hold, input int drop_at);
      int first;
      int pulses;
      logic [7:0] idx;
      idx = addr[7:0];
      if (wr) ref_mem[idx] = wd;
      else    exp_rdata = ref_mem[idx];
`ifdef MEM_RESP_PROTO_CHK_EN
      if (rd && wr) exp_proto = 1'b1;
      if (drop_at >= 1 && drop_at < LAT) exp_proto = 1'b1;
`endif
      mem_read  = rd;
      mem_write = wr;
      mem_addr  = addr;
      mem_wdata = wd;
      tick();
      first  = -1;
      pulses = 0;
      for (int k = 1; k <= LAT + 1 + hold; k++) begin
         tick();
         if (mem_ready) begin
            pulses++;
            if (first < 0) first = k;
         end
         if (k == LAT) chk("rdata_at_ready", mem_rdata, exp_rdata);
         if (k > LAT)  chk("rdata_hold", mem_rdata, exp_rdata);
         // Captured address/data must be used, not the live inputs.
         if (k == 1) begin
            mem_addr  = 28'($urandom);
            mem_wdata = rand_line();
         end
         if (k == drop_at) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
         end
      end
      mem_read  = 1'b0;
      mem_write = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         if (mem_ready) pulses++;
      end
      chk("ready_latency", 128'(first), 128'(LAT));
      chk("ready_pulses", 128'(pulses), 128'd1);
      chk("rdata_after", mem_rdata, exp_rdata);
      chk("proto_err", 128'(proto_err), 128'(exp_proto));
   endtask

   task automatic do_reset();
      proc_reset = 1'b1;
      tick();
      tick();
      proc_reset = 1'b0;
      exp_rdata = '0;
      exp_proto = 1'b0;
   endtask

   initial begin
      logic [127:0] v;
      proc_reset = 1'b1;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      exp_rdata  = '0;
      exp_proto  = 1'b0;

      // Reset then idle
      do_reset();
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_ready", 128'(mem_ready), 128'd0);
         chk("idle_rdata", mem_rdata, 128'd0);
         chk("idle_proto", 128'(proto_err), 128'd0);
      end

      // Preload the array through the hierarchy, mirrored in the model
      for (int i = 0; i < 256; i++) begin
         v = rand_line();
         dut.line_mem[i] = v;
         ref_mem[i] = v;
      end
      v = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A55A;
      dut.line_mem[8'h12] = v;
      ref_mem[8'h12] = v;
      dut.line_mem[7] = '0;
      ref_mem[7] = '0;

      // Preloaded read held 2 extra cycles
      txn(1'b1, 1'b0, 28'h12, '0, 2, -1);
      chk("preload_value", mem_rdata, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A55A);

      // Write then aliased read
      txn(1'b0, 1'b1, 28'h3, 128'h01234567_89ABCDEF_01234567_89ABCDEF, 0, -1);
      txn(1'b1, 1'b0, 28'h103, '0, 1, -1);
      chk("alias_read", mem_rdata, 128'h01234567_89ABCDEF_01234567_89ABCDEF);

      // Simultaneous read+write behaves as a write
      txn(1'b1, 1'b1, 28'h5, 128'h1, 0, -1);
      txn(1'b1, 1'b0, 28'h5, '0, 0, -1);
      chk("rw_then_read", mem_rdata, 128'h1);

      // Reset two cycles into a write: no pulse, no commit
      mem_write = 1'b1;
      mem_addr  = 28'h7;
      mem_wdata = 128'hFF;
      tick();
      tick();
      tick();
      proc_reset = 1'b1;
      mem_write  = 1'b0;
      tick();
      chk("rst_mid_ready", 128'(mem_ready), 128'd0);
      tick();
      chk("rst_mid_ready", 128'(mem_ready), 128'd0);
      proc_reset = 1'b0;
      exp_rdata = '0;
      exp_proto = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_mid_ready_after", 128'(mem_ready), 128'd0);
      end
      chk("rst_mid_rdata", mem_rdata, 128'd0);
      chk("rst_mid_proto", 128'(proto_err), 128'd0);
      txn(1'b1, 1'b0, 28'h7, '0, 0, -1);

      // Early deassert of a read during the busy phase
      txn(1'b1, 1'b0, 28'h12, '0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("proto_sticky", 128'(proto_err), 128'(exp_proto));
      end

      // Randomized traffic
      for (int n = 0; n < 24; n++) begin
         int op;
         op = $urandom_range(0, 9);
         txn((op < 6) || (op == 9), (op >= 6), 28'($urandom), rand_line(),
             $urandom_range(0, 2), -1);
      end

      // Reset clears the outputs and the sticky flag
      do_reset();
      tick();
      chk("final_rdata", mem_rdata, 128'd0);
      chk("final_proto", 128'(proto_err), 128'd0);
      chk("final_ready", 128'(mem_ready), 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_line_responder.md
# mem_line_responder

Line-granular memory responder serving the cache memory port (`mem_read`/`mem_write`/`mem_addr`/`mem_wdata` in, `mem_rdata`/`mem_ready` out). It sits below the instruction and data caches, holding 128-bit lines in a synchronous array. It returns each request after a fixed, parameterised latency with a one-cycle `mem_ready` pulse. `mem_rdata` is held stable afterwards so that a cache registering `mem_ready` one cycle late still samples valid data.

## Interface
- `DEPTH_LOG2`, 8: line-index width; array holds 2^DEPTH_LOG2 lines of 128 bits.
- `LATENCY`, 4: cycles from request-sampling edge to `mem_ready` high; legal range 1..15.
- `clk`  in  1  single clock; all state updates on rising edge.
- `proc_reset`  in  1  reset, synchronous, active-high.
- `mem_read`  in  1  read request level.
- `mem_write`  in  1  write request level.
- `mem_addr`  in  28  line address; only `[DEPTH_LOG2-1:0]` used, upper bits ignored (aliasing).
- `mem_wdata`  in  128  write line.
- `mem_rdata`  out  128  read line, registered.
- `mem_ready`  out  1  completion pulse, registered.
- `proto_err`  out  1  sticky protocol-violation flag (see Configuration).

## Operation
- States: S_IDLE, S_BUSY, S_RELEASE.
- S_IDLE:
  - At an edge where `mem_read|mem_write` is high: capture the index, the op, and `mem_wdata` (writes only), load the counter with LATENCY-1, and go to S_BUSY.
  - When both requests are high, the op is a write; the read is dropped.
- S_BUSY:
  - Counter decrements each edge.
  - At the edge where the counter is 0: `mem_ready`<=1 and go to S_RELEASE.
  - Read: `mem_rdata`<=array[index] at that same edge.
  - Write: array[index]<=captured wdata at that same edge; `mem_rdata` unchanged.
  - Inputs are ignored while busy; the captured address and data are used.
- S_RELEASE:
  - `mem_ready`<=0 at the next edge; `mem_ready` is high for exactly one cycle.
  - Stay in S_RELEASE until an edge samples `mem_read==0 && mem_write==0`, then go to S_IDLE.
  - A request still held high from the completed transaction is never re-served.
- `mem_rdata` holds its value until the next read completes; writes and idle cycles never disturb it.
- The array is not cleared by reset; contents are undefined until written (benches preload through a hierarchical path).

## Timing
- Reset values: `mem_ready`=0, `mem_rdata`=0, `proto_err`=0, state S_IDLE, counter 0.
- Request sampled at edge E0 → `mem_ready` high during the cycle following edge E0+LATENCY; `mem_rdata` valid from that same edge.
- With LATENCY=1, `mem_ready` rises at the edge after sampling.
- Minimum request spacing: a new request is accepted at the earliest one edge after the edge that samples both requests low in S_RELEASE.
  - Back-to-back throughput is 1 line per LATENCY+2 cycles at best.
- Read-after-write to the same index in a later transaction returns the new data.
- `proc_reset` mid-transaction (S_BUSY or S_RELEASE):
  - Return to S_IDLE, `mem_ready`=0, `mem_rdata`=0.
  - A pending write is not committed.
- Counter width is 4 bits; with LATENCY in 1..15 it cannot overflow.

## Configuration
- `MEM_RESP_PROTO_CHK_EN` defined:
  - `proto_err` sets to 1 on any edge in S_BUSY where the captured request's level (`mem_read` for reads, `mem_write` for writes) is sampled 0.
  - `proto_err` also sets on any edge in S_IDLE where `mem_read && mem_write`.
  - Once set, it stays 1 until `proc_reset`.
- Not defined: `proto_err` is tied to 0 and no checking logic is generated. Functional behaviour is otherwise identical.

## Test plan
- Reset then idle: hold `proc_reset` 2 cycles and release → `mem_ready`=0, `mem_rdata`=0, `proto_err`=0 for 10 idle cycles.
- Preloaded read, LATENCY=4:
  - Stimulus: array[8'h12]=128'hA5…5A; `mem_read`=1, `mem_addr`=28'h12 sampled at E0.
  - Required: `mem_ready` is a single-cycle pulse after E4; `mem_rdata`=128'hA5…5A and stays so for 5 following cycles while `mem_read` is held 2 more cycles; no second ready pulse.
- Write then read:
  - Stimulus: write 128'h0123…CDEF to 28'h3; release; read 28'h103 (aliases index 3).
  - Required: read returns 128'h0123…CDEF; `mem_rdata` unchanged across the write's ready pulse.
- Simultaneous read+write:
  - Stimulus: both high at address 5 with wdata 128'h1.
  - Required: treated as a write; `mem_rdata` is not updated; a later read of 5 returns 128'h1; `proto_err`=1 only with the macro.
- Reset mid-write:
  - Stimulus: write 128'hFF to index 7 (previously 128'h0); assert `proc_reset` 2 cycles after sampling.
  - Required: no ready pulse; a later read of 7 returns 128'h0.
- Early deassert with the macro defined:
  - Stimulus: drop `mem_read` during S_BUSY.
  - Required: the transaction still completes with one ready pulse; `proto_err`=1 and sticky until reset.
